// File: rtl/piso_pkg.sv
// piso_pkg: definitions shared by the PIPO-to-serial framing serializer.
//   state_t   - frame FSM states
//   LINE_IDLE - level held on the serial line between frames
//   START_BIT - level of the framing start bit
//   STOP_BIT  - level of the framing stop bit
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: bit-period timer for the serializer.
// Ports:
//   clk     - rising-edge clock
//   Reset   - synchronous, active-high; clears the counter
//   restart - begin a fresh bit period on the next cycle
//   tick    - high on the last cycle of each bit period
module bit_tick_gen #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic Reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Down-counter; reaching zero ends a period and starts the next one,
    // so consecutive periods need no explicit restart.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == '0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign tick = (r_cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: accepts a WIDTH-bit word over a valid/ready handshake and
// sends it on one serial line, optionally framed by start/stop bits.
// Ports:
//   clk        - rising-edge clock
//   Reset      - synchronous, active-high; aborts any frame in progress
//   I          - parallel word from the upstream PIPO stage
//   load_valid - upstream offers I this cycle
//   load_ready - block can accept a word (registered)
//   sout       - serial line, idles high (registered)
//   busy       - frame in progress (registered)
//   done       - one-cycle pulse on the IDLE cycle after a frame (registered)
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned FRAMED     = 1,
    parameter int unsigned LSB_FIRST  = 1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_n;
    logic [BW-1:0]    r_bitcnt;
    logic [BW-1:0]    w_bitcnt_n;
    logic             r_sout;
    logic             r_busy;
    logic             r_ready;
    logic             r_done;
    logic             w_sout_n;
    logic             w_done_n;
    logic             w_end_bit_n;
    logic             w_restart;
    logic             w_tick;

    bit_tick_gen #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_tick (
        .clk     (clk),
        .Reset   (Reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_comb begin
        w_state_n  = r_state;
        w_shreg_n  = r_shreg;
        w_bitcnt_n = r_bitcnt;
        w_restart  = 1'b0;

        case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_shreg_n  = I;
                    w_bitcnt_n = '0;
                    w_restart  = 1'b1;
                    w_state_n  = (FRAMED != 0) ? START : DATA;
                end
            end
            START: begin
                if (w_tick) begin
                    w_bitcnt_n = '0;
                    w_restart  = 1'b1;
                    w_state_n  = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_restart = 1'b1;
                    w_shreg_n = (LSB_FIRST != 0) ? (r_shreg >> 1) : (r_shreg << 1);
                    if (r_bitcnt == LAST_BIT) begin
                        w_state_n = (FRAMED != 0) ? STOP : IDLE;
                    end else begin
                        w_bitcnt_n = r_bitcnt + BW'(1);
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_restart = 1'b1;
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        // while still changing on the same edge as the state itself.
        w_end_bit_n = (LSB_FIRST != 0) ? w_shreg_n[0] : w_shreg_n[WIDTH-1];

        w_sout_n = LINE_IDLE;
        case (w_state_n)
            START:   w_sout_n = START_BIT;
            DATA:    w_sout_n = w_end_bit_n;
            STOP:    w_sout_n = STOP_BIT;
            default: w_sout_n = LINE_IDLE;
        endcase

        w_done_n = (w_state_n == IDLE) && (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_sout   <= LINE_IDLE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_shreg  <= w_shreg_n;
            r_bitcnt <= w_bitcnt_n;
            r_sout   <= w_sout_n;
            r_busy   <= (w_state_n != IDLE);
            r_ready  <= (w_state_n == IDLE);
            r_done   <= w_done_n;
        end
    end

    assign sout       = r_sout;
    assign busy       = r_busy;
    assign load_ready = r_ready;
    assign done       = r_done;

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out framing serializer that sits directly downstream of the 6-bit PIPO register stage. It captures the registered 6-bit word through a valid/ready handshake and shifts it out one bit per bit period on a single line, optionally wrapped in start and stop bits. A busy indication and a one-cycle done pulse let the upstream stage pace its loads.

## Interface
- WIDTH, 6, data bits per word
- BIT_CYCLES, 1, clock cycles per serial bit (≥1)
- FRAMED, 1, 1 = add start bit (0) and stop bit (1); 0 = raw data bits only
- LSB_FIRST, 1, 1 = bit 0 shifted first; 0 = bit WIDTH-1 first

Ports:
- clk  in  1  rising-edge clock; one clock; reset is synchronous and active-high
- Reset  in  1  synchronous, active-high; sampled on rising clk
- I  in  WIDTH  parallel word from the PIPO output
- load_valid  in  1  upstream offers I this cycle
- load_ready  out  1  block can accept a word
- sout  out  1  serial line; idles high
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when a frame completes

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE: load_ready=1, busy=0, sout=1. On load_valid && load_ready at a rising edge, capture I into an internal shift register. Then go to START if FRAMED=1, otherwise go to DATA.
- START: sout=0 for one bit period, then go to DATA.
- DATA: sout = the current shift-register end bit (LSB or MSB per LSB_FIRST). Shift at the end of each bit period. The bit counter runs 0..WIDTH-1. After WIDTH periods, go to STOP if FRAMED=1, otherwise go to IDLE.
- STOP: sout=1 for one bit period, then go to IDLE.
- done=1 for exactly the first IDLE cycle after a completed frame.
- busy = (state != IDLE); load_ready = ~busy.
- I and load_valid are ignored while busy. The captured word is immune to later changes on I.
- A bit period is BIT_CYCLES clocks, timed by a down-counter. The counter reloads to BIT_CYCLES-1 on every state entry and on every data-bit advance.

## Timing
- Reset values: state=IDLE, sout=1, busy=0, load_ready=1, done=0, shift register=0, counters=0.
- Reset mid-frame aborts the frame. From the next edge: sout=1, load_ready=1, and no done pulse.
- Reset takes priority over a simultaneous load.
- Latency: the first frame bit appears on sout the cycle after the accepting edge.
- Frame length is (WIDTH + 2·FRAMED)·BIT_CYCLES cycles.
- Minimum spacing between accepts is frame length + 1 cycle, because of the mandatory IDLE cycle. That IDLE cycle coincides with done=1 and load_ready=1.
- A load may be accepted on the done cycle. The next frame then starts on the following cycle.
- load_valid held high through a frame produces exactly one accept per IDLE visit.
- All outputs are registered; no combinational path from I or load_valid to sout.

## Structure
- Shared package piso_pkg:
  - state enum (IDLE, START, DATA, STOP)
  - line constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1
- Sub-module bit_tick_gen (parameter BIT_CYCLES):
  - inputs: clk, Reset, restart
  - output: tick, high on the last cycle of each bit period
  - the FSM advances only on tick
- Top level holds the FSM, the shift register and the WIDTH bit counter, sized $clog2(WIDTH).

## Test plan
- Defaults; after reset, load I=12 (001100): sout = 0,0,0,1,1,0,0,1, one per cycle from the cycle after accept. done pulses at cycle 9. busy is high for cycles 1–8.
- I=8 with FRAMED=0, LSB_FIRST=0: sout = 0,0,1,0,0,0. No start or stop bits. done follows the last bit.
- BIT_CYCLES=3, I=63: each bit is held exactly 3 cycles. The frame lasts 24 cycles, then done.
- Hold load_valid=1 with changing I during the frame: only the first word is transmitted. The second accept happens on the done cycle, and the back-to-back frame starts with no gap.
- Assert Reset during data bit 3: the next cycle gives sout=1, busy=0, load_ready=1, done=0. A fresh load of I=5 then transmits correctly.
- Reset high together with load_valid=1: no accept, and the line stays idle.
